// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared AHB-to-APB bridge encodings, window defaults and error-FSM states
package ahb_apb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [1:0] HRESP_OKAY = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [31:0] SLV0_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE_DEF = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE_DEF = 32'h8800_0000;
  localparam int WIN_BITS_DEF = 26;
  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_ERR1 = 2'd1,
    ERR_ERR2 = 2'd2
  } err_state_e;
  // XOR-then-shift compares only the bits above the window offset
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base, input int win_bits);
    return ((addr ^ base) >> win_bits) == 32'd0;
  endfunction
endpackage

// File: rtl/ahb_addr_decode.sv
// ahb_addr_decode: one-hot peripheral select and size/alignment/unmapped error flag
module ahb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] SLV0_BASE = SLV0_BASE_DEF,
  parameter logic [31:0] SLV1_BASE = SLV1_BASE_DEF,
  parameter logic [31:0] SLV2_BASE = SLV2_BASE_DEF,
  parameter int WIN_BITS = WIN_BITS_DEF
) (
  input  logic [31:0] haddr_i,
  input  logic [2:0]  hsize_i,
  output logic [2:0]  tempselx_o,
  output logic        illegal_o
);
  always_comb begin
    tempselx_o = {in_window(haddr_i, SLV2_BASE, WIN_BITS),
                  in_window(haddr_i, SLV1_BASE, WIN_BITS),
                  in_window(haddr_i, SLV0_BASE, WIN_BITS)};
    illegal_o = (tempselx_o == 3'b000) || (hsize_i > 3'd2) ||
                (hsize_i == 3'd1 && haddr_i[0]) ||
                (hsize_i == 3'd2 && haddr_i[1:0] != 2'b00);
  end
endmodule

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB-Lite slave front end -- qualifies phases, pipelines address/data, drives ERROR response
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] SLV0_BASE = SLV0_BASE_DEF,
  parameter logic [31:0] SLV1_BASE = SLV1_BASE_DEF,
  parameter logic [31:0] SLV2_BASE = SLV2_BASE_DEF,
  parameter int WIN_BITS = WIN_BITS_DEF
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        valid,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic [2:0]  tempselx,
  output logic [1:0]  Hresp,
  output logic        Hready_err
);
  err_state_e state_q, state_d;
  logic [31:0] haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
  logic        hwrite_q;
  logic        active, bad, illegal;
  ahb_addr_decode #(
    .SLV0_BASE(SLV0_BASE),
    .SLV1_BASE(SLV1_BASE),
    .SLV2_BASE(SLV2_BASE),
    .WIN_BITS (WIN_BITS)
  ) u_dec (
    .haddr_i   (Haddr),
    .hsize_i   (Hsize),
    .tempselx_o(tempselx),
    .illegal_o (bad)
  );
  // ERR1 holds the bus low, so no phase is ever qualified in it
  always_comb begin
    active = Hreadyin && Htrans != HTRANS_IDLE && Htrans != HTRANS_BUSY && state_q != ERR_ERR1;
    illegal = active && bad;
    valid = active && !bad && !Hreset;
    state_d = state_q == ERR_ERR1 ? ERR_ERR2 : illegal ? ERR_ERR1 : ERR_IDLE;
    Hresp = state_q == ERR_IDLE ? HRESP_OKAY : HRESP_ERROR;
    Hready_err = state_q != ERR_ERR1;
  end
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q <= ERR_IDLE;
      haddr1_q <= '0;
      haddr2_q <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (Hreadyin) begin
        haddr1_q <= Haddr;
        haddr2_q <= haddr1_q;
        hwdata1_q <= Hwdata;
        hwdata2_q <= hwdata1_q;
        hwrite_q <= Hwrite;
      end
    end
  end
  assign Haddr1 = haddr1_q;
  assign Haddr2 = haddr2_q;
  assign Hwdata1 = hwdata1_q;
  assign Hwdata2 = hwdata2_q;
  assign Hwritereg = hwrite_q;
endmodule

// File: doc/ahb_slave_if.md
# ahb_slave_if

AHB-Lite slave front end of the AHB-to-APB bridge, directly upstream of `APB_Controller`. It qualifies AHB address phases and decodes the peripheral select. It pipelines address, write data and direction into the one- and two-stage copies that `APB_Controller` consumes. It issues the two-cycle AHB ERROR response for illegal accesses.

## Interface

**Parameters**
- `SLV0_BASE`, default `32'h8000_0000`: base of peripheral 0 window.
- `SLV1_BASE`, default `32'h8400_0000`: base of peripheral 1 window.
- `SLV2_BASE`, default `32'h8800_0000`: base of peripheral 2 window.
- `WIN_BITS`, default `26`: window size is 2^WIN_BITS bytes (64 MiB).

**Ports**
- `Hclk` in 1: the single clock.
- `Hreset` in 1: synchronous reset, active-high.
- `Hwrite` in 1: AHB direction, 1 = write.
- `Hreadyin` in 1: bus HREADY, i.e. `Hreadyout & Hready_err`, combined at top level.
- `Htrans` in 2: AHB transfer type.
- `Hsize` in 3: AHB transfer size.
- `Haddr` in 32: AHB address.
- `Hwdata` in 32: AHB write data.
- `valid` out 1: legal active address phase this cycle.
- `Haddr1`, `Haddr2` out 32: `Haddr` delayed one and two accepted phases.
- `Hwdata1`, `Hwdata2` out 32: `Hwdata` delayed likewise.
- `Hwritereg` out 1: `Hwrite` of the last accepted address phase.
- `tempselx` out 3: one-hot peripheral select decoded from `Haddr`.
- `Hresp` out 2: `00` OKAY, `01` ERROR.
- `Hready_err` out 1: this block's HREADY contribution.

## Operation
- **Active phase**: `Hreadyin=1` and `Htrans` is `NONSEQ` (10) or `SEQ` (11). `IDLE` and `BUSY` are never active.
- **Decode, combinational from `Haddr`**: `SLV0` window gives `001`, `SLV1` gives `010`, `SLV2` gives `100`, anything else gives `000`.
- **Illegal access**: the phase is active and at least one of these holds:
  - `tempselx==000`
  - `Hsize>2`
  - `Hsize==1` with `Haddr[0]` set
  - `Hsize==2` with `Haddr[1:0]≠0`
- **`valid`**: combinational. It is 1 only for an active phase that is not illegal. Otherwise it is 0, including throughout ERR1.
- **Pipeline registers**:
  - Update only when `Hreadyin=1`: `Haddr1<=Haddr`, `Haddr2<=Haddr1`, `Hwdata1<=Hwdata`, `Hwdata2<=Hwdata1`, `Hwritereg<=Hwrite`.
  - Hold when `Hreadyin=0`.
- **Error FSM**, states IDLE, ERR1, ERR2:
  - IDLE → ERR1 on an illegal access; otherwise stay in IDLE.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → ERR1 if the phase presented in ERR2 is illegal; otherwise ERR2 → IDLE.
  - IDLE: `Hresp=00`, `Hready_err=1`.
  - ERR1: `Hresp=01`, `Hready_err=0`.
  - ERR2: `Hresp=01`, `Hready_err=1`.
- **Reset**: applies on a clock edge with `Hreset=1`, including mid-error. Afterwards the FSM is in IDLE, all pipeline registers and `Hwritereg` are 0, `Hresp=00`, `Hready_err=1`.
- While `Hreset=1`, `valid` is forced to 0.

## Timing
- `valid` and `tempselx` have zero latency: they are valid in the address-phase cycle.
- `Haddr1` and `Hwritereg` are valid in the data-phase cycle, one edge after acceptance. `Haddr2` follows one accepted phase later.
- `Hwdata1` captures the data phase on the edge that ends it. `Hwdata2` follows one edge after that.
- An ERROR response occupies the two cycles after the illegal address phase. `Hready_err` is low in the first cycle only.
- A legal phase presented in ERR2 is accepted normally: `valid=1` and the pipeline updates.
- If `Hreadyin=0` while the FSM is in IDLE, `APB_Controller` is stalling. `valid` stays 0 and the registers hold.

## Structure
- Shared bridge package `ahb_apb_pkg` holds:
  - `Htrans` encodings (IDLE, BUSY, NONSEQ, SEQ)
  - `Hresp` encodings
  - the three window base constants
  - the `WIN_BITS` default
  - the error-FSM state enum
- Natural sub-module: `ahb_addr_decode`. It is combinational: `Haddr`, `Hsize` in; `tempselx`, illegal flag out. It is reused by the bench scoreboard.

## Test plan
1. **Reset mid-ERR1.** Stimulus: assert `Hreset` during ERR1. Required: next cycle shows `Hresp=00`, `Hready_err=1`, `Haddr1=0`, `Hwritereg=0`.
2. **Legal NONSEQ write.** Stimulus: `Haddr=8c00_1234`. Required:
   - with default bases, `8c00_1234` is unmapped, so `valid=0`, `tempselx=000`, then ERR1 (`Hresp=01`, `Hready_err=0`), then ERR2 (`Hresp=01`, `Hready_err=1`);
   - a repeat with `Haddr=8000_0010`, `Hwrite=1`, `Hsize=2` gives `valid=1` and `tempselx=001`, then `Haddr1=8000_0010` and `Hwritereg=1` one edge later.
3. **Back-to-back pipeline.**
   - Stimulus: SEQ reads at `8400_0000` then `8400_0004` with `Hreadyin=1`.
   - Required: `tempselx=010` both cycles; `Haddr2=8400_0000` when `Haddr1=8400_0004`.
4. **Stall.** Stimulus: `Hreadyin=0` for 2 cycles after an accepted `8800_0000` write with `Hwdata=8500_0000`. Required: `Haddr1` holds `8800_0000` and `valid=0` during the stall; `Hwdata1=8500_0000` after release.
5. **Alignment and size errors.**
   - Stimulus: `Hsize=2`, `Haddr=8000_0002`, then `Hsize=3`, `Haddr=8000_0000`.
   - Required: each gives `valid=0` and a two-cycle ERROR.
6. **Non-transfers.** Stimulus: `Htrans=IDLE` and `BUSY` at `8000_0000`. Required: `valid=0`, `Hresp=00`, pipeline still advances.
